// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundles the PC control, instruction-memory and execute-stage
// signals of the fetch/execute sequencer. Signal prefixes give the direction as
// seen from the sequencer (i_ = into the sequencer, o_ = out of it).
// Optional feature: defining PC_SEQUENCER_IRQ_EN adds i_irq, o_irq_ack and o_epc.
interface pc_sequencer_if;

  // Program counter side
  logic [15:0] i_pc_value;
  logic        o_pc_load_en;
  logic [15:0] o_pc_load_value;
  logic        o_pc_offset_en;
  logic [8:0]  o_pc_offset;
  logic        o_pc_advance;

  // Instruction memory side
  logic        o_instr_req;
  logic [15:0] o_instr_addr;
  logic        i_instr_ack;
  logic [15:0] i_instr_data;
  logic [15:0] o_instr_reg;
  logic        o_instr_valid;

  // Execute stage side
  logic        i_exec_done;
  logic        i_jump_req;
  logic [15:0] i_jump_target;
  logic        i_branch_req;
  logic [8:0]  i_branch_offset;

  // Run control and status
  logic        i_halt_req;
  logic        i_resume;
  logic        o_halted;
  logic        o_fetch_error;

`ifdef PC_SEQUENCER_IRQ_EN
  // Interrupt entry
  logic        i_irq;
  logic        o_irq_ack;
  logic [15:0] o_epc;
`endif

  // Sequencer view
  modport master (
`ifdef PC_SEQUENCER_IRQ_EN
    input  i_irq,
    output o_irq_ack,
    output o_epc,
`endif
    input  i_pc_value,
    output o_pc_load_en,
    output o_pc_load_value,
    output o_pc_offset_en,
    output o_pc_offset,
    output o_pc_advance,
    output o_instr_req,
    output o_instr_addr,
    input  i_instr_ack,
    input  i_instr_data,
    output o_instr_reg,
    output o_instr_valid,
    input  i_exec_done,
    input  i_jump_req,
    input  i_jump_target,
    input  i_branch_req,
    input  i_branch_offset,
    input  i_halt_req,
    input  i_resume,
    output o_halted,
    output o_fetch_error
  );

  // Environment view: PC, instruction memory and execute stage
  modport slave (
`ifdef PC_SEQUENCER_IRQ_EN
    output i_irq,
    input  o_irq_ack,
    input  o_epc,
`endif
    output i_pc_value,
    input  o_pc_load_en,
    input  o_pc_load_value,
    input  o_pc_offset_en,
    input  o_pc_offset,
    input  o_pc_advance,
    input  o_instr_req,
    input  o_instr_addr,
    output i_instr_ack,
    output i_instr_data,
    input  o_instr_reg,
    input  o_instr_valid,
    output i_exec_done,
    output i_jump_req,
    output i_jump_target,
    output i_branch_req,
    output i_branch_offset,
    output i_halt_req,
    output i_resume,
    input  o_halted,
    input  o_fetch_error
  );

endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute control FSM for a 16-bit program counter.
// Runs the instruction-memory req/ack handshake with a fetch-timeout watchdog,
// latches the fetched word, records the execute stage's jump/branch/advance
// decision and issues exactly one PC update strobe per instruction.
// Halt/resume at instruction boundaries; a fetch timeout halts permanently
// until reset. Reset is synchronous and active-high.
// Optional feature: define PC_SEQUENCER_IRQ_EN to add level interrupt entry
// (IRQ state, IrqAck pulse, Epc capture, PC load of IRQ_VECTOR).
module pc_sequencer #(
  parameter int unsigned FETCH_TIMEOUT = 16,       // legal range 2..255
  parameter logic [15:0] IRQ_VECTOR    = 16'h0004
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pc_sequencer_if.master io_seq
);

  // Last counter value at which FETCH still waits; no ack here means timeout.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
`ifdef PC_SEQUENCER_IRQ_EN
    ,
    ST_IRQ    = 3'd5
`endif
  } state_t;

  // What the UPDATE cycle does to the PC.
  typedef enum logic [1:0] {
    DEC_ADVANCE = 2'd0,
    DEC_BRANCH  = 2'd1,
    DEC_JUMP    = 2'd2
  } decision_t;

  state_t      r_state;
  state_t      w_state_next;
  decision_t   r_decision;
  logic [7:0]  r_timeout_cnt;
  logic [15:0] r_instr_reg;
  logic        r_instr_valid;
  logic        r_fetch_error;
  logic [15:0] r_load_value;
  logic [8:0]  r_offset;
  logic        w_timeout_hit;

  logic        w_pc_load_en;
  logic [15:0] w_pc_load_value;
  logic        w_pc_offset_en;
  logic        w_pc_advance;
  logic        w_instr_req;
  logic        w_halted;

`ifdef PC_SEQUENCER_IRQ_EN
  logic [15:0] r_epc;
  logic        w_irq_ack;
`else
  // The vector only matters for interrupt entry; fold it away in this build.
  logic        w_unused_irq_vector;
  assign w_unused_irq_vector = ^IRQ_VECTOR;
`endif

  assign w_timeout_hit = (r_timeout_cnt == TIMEOUT_LAST);

  // State register
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; HaltReq (and Irq) only matter at instruction boundaries
  always_comb begin
    // NOTE: default first so no path through the case leaves the signal
    // unassigned, which would infer a latch.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        w_state_next = i_halt_req_w() ? ST_HALT : ST_FETCH;
      end
      ST_FETCH: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (io_seq.i_instr_ack) begin
          w_state_next = ST_EXEC;
        end else if (w_timeout_hit) begin
          w_state_next = ST_HALT;
        end
      end
      ST_EXEC: begin
        if (io_seq.i_exec_done) begin
          w_state_next = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
`ifdef PC_SEQUENCER_IRQ_EN
        if (io_seq.i_irq) begin
          w_state_next = ST_IRQ;
        end else
`endif
        if (i_halt_req_w()) begin
          w_state_next = ST_HALT;
        end else begin
          w_state_next = ST_FETCH;
        end
      end
      ST_HALT: begin
        // A fetch error is terminal until reset.
        if (io_seq.i_resume && !r_fetch_error) begin
          w_state_next = ST_FETCH;
        end
      end
`ifdef PC_SEQUENCER_IRQ_EN
      ST_IRQ: begin
        w_state_next = ST_FETCH;
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  function automatic logic i_halt_req_w();
    return io_seq.i_halt_req;
  endfunction

  // Fetch datapath: timeout counter, instruction latch, valid pulse, sticky error
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timeout_cnt <= 8'd0;
      r_instr_reg   <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_fetch_error <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      if (r_state == ST_FETCH) begin
        if (io_seq.i_instr_ack) begin
          r_instr_reg   <= io_seq.i_instr_data;
          r_instr_valid <= 1'b1;
          r_timeout_cnt <= 8'd0;
        end else if (w_timeout_hit) begin
          r_fetch_error <= 1'b1;
          r_timeout_cnt <= 8'd0;
        end else begin
          r_timeout_cnt <= r_timeout_cnt + 8'd1;
        end
      end
    end
  end

  // Decision capture at ExecDone; jump has priority over branch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_decision   <= DEC_ADVANCE;
      r_load_value <= 16'h0000;
      r_offset     <= 9'h000;
    end else if ((r_state == ST_EXEC) && io_seq.i_exec_done) begin
      if (io_seq.i_jump_req) begin
        r_decision   <= DEC_JUMP;
        r_load_value <= io_seq.i_jump_target;
      end else if (io_seq.i_branch_req) begin
        r_decision <= DEC_BRANCH;
        r_offset   <= io_seq.i_branch_offset;
      end else begin
        r_decision <= DEC_ADVANCE;
      end
    end
  end

`ifdef PC_SEQUENCER_IRQ_EN
  // Exception PC: the PC value already updated by the preceding UPDATE strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_epc <= 16'h0000;
    end else if (r_state == ST_IRQ) begin
      r_epc <= io_seq.i_pc_value;
    end
  end
`endif

  // Output decode: strobes and status are pure functions of state and decision
  always_comb begin
    w_pc_load_en    = 1'b0;
    w_pc_load_value = r_load_value;
    w_pc_offset_en  = 1'b0;
    w_pc_advance    = 1'b0;
    w_instr_req     = 1'b0;
    w_halted        = 1'b0;
`ifdef PC_SEQUENCER_IRQ_EN
    w_irq_ack       = 1'b0;
`endif
    case (r_state)
      ST_FETCH: begin
        w_instr_req = 1'b1;
      end
      ST_UPDATE: begin
        case (r_decision)
          DEC_JUMP:    w_pc_load_en   = 1'b1;
          DEC_BRANCH:  w_pc_offset_en = 1'b1;
          DEC_ADVANCE: w_pc_advance   = 1'b1;
          default:     w_pc_advance   = 1'b0;
        endcase
      end
      ST_HALT: begin
        w_halted = 1'b1;
      end
`ifdef PC_SEQUENCER_IRQ_EN
      ST_IRQ: begin
        w_pc_load_en    = 1'b1;
        w_pc_load_value = IRQ_VECTOR;
        w_irq_ack       = 1'b1;
      end
`endif
      default: begin
        w_instr_req = 1'b0;
      end
    endcase
  end

  assign io_seq.o_pc_load_en    = w_pc_load_en;
  assign io_seq.o_pc_load_value = w_pc_load_value;
  assign io_seq.o_pc_offset_en  = w_pc_offset_en;
  assign io_seq.o_pc_offset     = r_offset;
  assign io_seq.o_pc_advance    = w_pc_advance;
  assign io_seq.o_instr_req     = w_instr_req;
  // The fetch address is the live PC; the sequencer never modifies addresses.
  assign io_seq.o_instr_addr    = io_seq.i_pc_value;
  assign io_seq.o_instr_reg     = r_instr_reg;
  assign io_seq.o_instr_valid   = r_instr_valid;
  assign io_seq.o_halted        = w_halted;
  assign io_seq.o_fetch_error   = r_fetch_error;
`ifdef PC_SEQUENCER_IRQ_EN
  assign io_seq.o_irq_ack       = w_irq_ack;
  assign io_seq.o_epc           = r_epc;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer. The bench plays the PC,
// the instruction memory and the execute stage; a reference PC is advanced
// from each instruction's decision, and a monitor pops expected fetch words
// and PC updates whenever the sequencer presents InstrValid or a PC strobe.
module tb_pc_sequencer;

  localparam int          TIMEOUT = 4;
  localparam logic [15:0] PC_INIT = 16'h0010;
  localparam logic [15:0] IRQ_VEC = 16'h0004;

  typedef enum {K_ADV, K_BR, K_JMP} kind_e;
  typedef struct {kind_e kind; logic [15:0] value;} upd_t;

  logic clk;
  logic rst;
  pc_sequencer_if bus ();

  pc_sequencer #(.FETCH_TIMEOUT(TIMEOUT), .IRQ_VECTOR(IRQ_VEC)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_seq (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          fetch_cyc = 0;
  logic [15:0] ref_pc;
  logic [15:0] ref_epc;
  logic [15:0] q_ins[$];
  upd_t        q_upd[$];
  logic [15:0] pc_q;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Behavioural program counter driven by the sequencer's strobes
  always @(posedge clk) begin
    if (rst) pc_q <= PC_INIT;
    else if (bus.o_pc_load_en) pc_q <= bus.o_pc_load_value;
    else if (bus.o_pc_offset_en) pc_q <= pc_q + {{7{bus.o_pc_offset[8]}}, bus.o_pc_offset};
    else if (bus.o_pc_advance) pc_q <= pc_q + 16'd1;
  end
  assign bus.i_pc_value = pc_q;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: compare whatever the sequencer presents against the scoreboard
  initial begin
    upd_t        u;
    logic [15:0] w;
    int          nstrobe;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.o_instr_valid) begin
          check("instr_valid_expected", 32'(q_ins.size() != 0), 1);
          if (q_ins.size() != 0) begin
            w = q_ins.pop_front();
            check("instr_reg", bus.o_instr_reg, w);
          end
        end
        nstrobe = int'(bus.o_pc_load_en) + int'(bus.o_pc_offset_en) + int'(bus.o_pc_advance);
        if (nstrobe != 0) begin
          check("one_strobe", nstrobe, 1);
          check("strobe_expected", 32'(q_upd.size() != 0), 1);
          if (q_upd.size() != 0) begin
            u = q_upd.pop_front();
            case (u.kind)
              K_JMP: begin
                check("pc_load_en", bus.o_pc_load_en, 1);
                check("pc_load_value", bus.o_pc_load_value, u.value);
              end
              K_BR: begin
                check("pc_offset_en", bus.o_pc_offset_en, 1);
                check("pc_offset", bus.o_pc_offset, u.value[8:0]);
              end
              default: check("pc_advance", bus.o_pc_advance, 1);
            endcase
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.i_instr_ack     = 1'b0;
    bus.i_instr_data    = 16'h0000;
    bus.i_exec_done     = 1'b0;
    bus.i_jump_req      = 1'b0;
    bus.i_jump_target   = 16'h0000;
    bus.i_branch_req    = 1'b0;
    bus.i_branch_offset = 9'h000;
    bus.i_halt_req      = 1'b0;
    bus.i_resume        = 1'b0;
`ifdef PC_SEQUENCER_IRQ_EN
    bus.i_irq           = 1'b0;
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_instr_req"}, bus.o_instr_req, 0);
    check({tag, "_halted"}, bus.o_halted, 0);
    check({tag, "_fetch_error"}, bus.o_fetch_error, 0);
    check({tag, "_load_en"}, bus.o_pc_load_en, 0);
    check({tag, "_offset_en"}, bus.o_pc_offset_en, 0);
    check({tag, "_advance"}, bus.o_pc_advance, 0);
    check({tag, "_instr_valid"}, bus.o_instr_valid, 0);
    check({tag, "_instr_reg"}, bus.o_instr_reg, 0);
    check({tag, "_load_value"}, bus.o_pc_load_value, 0);
    check({tag, "_offset"}, bus.o_pc_offset, 0);
`ifdef PC_SEQUENCER_IRQ_EN
    check({tag, "_irq_ack"}, bus.o_irq_ack, 0);
    check({tag, "_epc"}, bus.o_epc, 0);
`endif
  endtask

  // Reset for two cycles (optionally with HaltReq held), then check the reset state
  task automatic do_reset(input string tag, input bit halt);
    rst = 1'b1;
    clear_inputs();
    bus.i_halt_req = halt;
    q_ins.delete();
    q_upd.delete();
    ref_pc = PC_INIT;
    repeat (2) @(negedge clk);
    check_zero(tag);
    rst = 1'b0;
  endtask

  // Wait (bounded) for InstrReq; returns at the negedge of the first FETCH cycle
  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.i_resume = 1'b0;
      if (bus.o_instr_req) begin
        found = 1'b1;
        break;
      end
    end
    fetch_cyc = cyc;
    check("instr_req_seen", 32'(found), 1);
  endtask

  // One instruction: ack after ack_d wait cycles, ExecDone after done_d EXEC cycles.
  // Returns at the negedge of the UPDATE cycle.
  task automatic run_instr(input int ack_d, input int done_d, input bit jmp,
                           input logic [15:0] tgt, input bit br, input logic [8:0] off,
                           input bit hold_halt, input bit irq_upd);
    bit          found;
    logic [15:0] data;
    upd_t        u;
    int          soff;
    wait_req(found);
    if (!found) return;
    check("fetch_addr", bus.o_instr_addr, ref_pc);
    repeat (ack_d) @(negedge clk);
    data = 16'($urandom);
    bus.i_instr_ack  = 1'b1;
    bus.i_instr_data = data;
    q_ins.push_back(data);
    @(negedge clk);
    bus.i_instr_ack = 1'b0;
    repeat (done_d) @(negedge clk);
    bus.i_exec_done     = 1'b1;
    bus.i_jump_req      = jmp;
    bus.i_jump_target   = tgt;
    bus.i_branch_req    = br;
    bus.i_branch_offset = off;
    if (hold_halt) bus.i_halt_req = 1'b1;
    if (jmp) begin
      u.kind = K_JMP; u.value = tgt;
      ref_pc = tgt;
    end else if (br) begin
      u.kind = K_BR; u.value = {7'd0, off};
      soff = int'(off);
      if (off[8]) soff -= 512;
      ref_pc = 16'(int'(ref_pc) + soff);
    end else begin
      u.kind = K_ADV; u.value = 16'h0000;
      ref_pc = ref_pc + 16'd1;
    end
    q_upd.push_back(u);
`ifdef PC_SEQUENCER_IRQ_EN
    if (irq_upd) begin
      bus.i_irq = 1'b1;
      ref_epc = ref_pc;
      u.kind = K_JMP; u.value = IRQ_VEC;
      q_upd.push_back(u);
      ref_pc = IRQ_VEC;
    end
`endif
    @(negedge clk);
    bus.i_exec_done  = 1'b0;
    bus.i_jump_req   = 1'b0;
    bus.i_branch_req = 1'b0;
  endtask

  initial begin
    bit found;
    int prev_cyc;
    rst = 1'b1;
    clear_inputs();
    ref_pc  = PC_INIT;
    ref_epc = 16'h0000;

    // Reset state
    do_reset("reset", 1'b0);

    // Back-to-back advances: one instruction every 3 cycles
    for (int i = 0; i < 8; i++) begin
      run_instr(0, 0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0);
      if (i > 0) check("instr_period", fetch_cyc - prev_cyc, 3);
      prev_cyc = fetch_cyc;
    end

    // Jump beats branch; negative and zero branch offsets
    run_instr(0, 0, 1'b1, 16'h1234, 1'b1, 9'h0AB, 1'b0, 1'b0);
    run_instr(0, 0, 1'b0, 16'h0000, 1'b1, 9'h1FE, 1'b0, 1'b0);
    run_instr(0, 1, 1'b0, 16'hBEEF, 1'b1, 9'h000, 1'b0, 1'b0);

    // Ack on the final timeout cycle still wins
    run_instr(TIMEOUT - 1, 2, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0);
    check("late_ack_no_error", bus.o_fetch_error, 0);
    check("late_ack_not_halted", bus.o_halted, 0);

    // Randomised instruction stream
    for (int i = 0; i < 60; i++) begin
      run_instr($urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3),
                $urandom_range(0, 3) == 0, 16'($urandom),
                $urandom_range(0, 2) == 0, 9'($urandom), 1'b0, 1'b0);
    end

    // HaltReq during EXEC: strobe still issued, then HALT, Resume refetches
    run_instr(1, 1, 1'b0, 16'h0000, 1'b1, 9'h005, 1'b1, 1'b0);
    @(negedge clk);
    bus.i_halt_req = 1'b0;
    check("halt_after_update", bus.o_halted, 1);
    check("halt_no_req", bus.o_instr_req, 0);
    repeat (2) @(negedge clk);
    check("halt_holds", bus.o_halted, 1);
    bus.i_resume = 1'b1;
    run_instr(0, 0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0);
    check("resumed_not_halted", bus.o_halted, 0);

    // Reset mid-EXEC (after a jump left PcLoadValue nonzero)
    run_instr(0, 0, 1'b1, 16'hA5A5, 1'b0, 9'h000, 1'b0, 1'b0);
    wait_req(found);
    bus.i_instr_ack  = 1'b1;
    bus.i_instr_data = 16'h5A5A;
    q_ins.push_back(16'h5A5A);
    @(negedge clk);
    bus.i_instr_ack = 1'b0;
    do_reset("rst_exec", 1'b0);

    // Reset mid-FETCH abandons the handshake
    wait_req(found);
    do_reset("rst_fetch", 1'b0);

    // HaltReq in IDLE goes straight to HALT; Resume starts fetching
    do_reset("rst_halt", 1'b1);
    @(negedge clk);
    bus.i_halt_req = 1'b0;
    check("idle_halt", bus.o_halted, 1);
    check("idle_halt_no_req", bus.o_instr_req, 0);
    bus.i_resume = 1'b1;
    run_instr(0, 0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0);

    // Fetch timeout: 4 FETCH cycles without ack, then sticky error and HALT
    do_reset("rst_to", 1'b0);
    wait_req(found);
    for (int i = 1; i < TIMEOUT; i++) begin
      @(negedge clk);
      check("timeout_still_fetching", bus.o_instr_req, 1);
      check("timeout_no_error_yet", bus.o_fetch_error, 0);
    end
    @(negedge clk);
    check("timeout_error", bus.o_fetch_error, 1);
    check("timeout_halted", bus.o_halted, 1);
    check("timeout_req_dropped", bus.o_instr_req, 0);
    bus.i_resume = 1'b1;
    @(negedge clk);
    bus.i_resume = 1'b0;
    repeat (2) @(negedge clk);
    check("resume_ignored_halted", bus.o_halted, 1);
    check("resume_ignored_error", bus.o_fetch_error, 1);
    check("resume_ignored_req", bus.o_instr_req, 0);
    do_reset("rst_clear", 1'b0);

`ifdef PC_SEQUENCER_IRQ_EN
    // Interrupt entry after PC advances 0x0010 -> 0x0011
    run_instr(0, 0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b1);
    @(negedge clk);
    bus.i_irq = 1'b0;
    check("irq_ack", bus.o_irq_ack, 1);
    check("irq_load_value", bus.o_pc_load_value, IRQ_VEC);
    @(negedge clk);
    check("irq_ack_pulse", bus.o_irq_ack, 0);
    check("epc", bus.o_epc, ref_epc);
    run_instr(0, 0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0);
`endif

    // Everything expected was observed
    run_instr(0, 0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("instr_queue_drained", q_ins.size(), 0);
    check("update_queue_drained", q_upd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch/execute control state machine that drives the 16-bit program counter's load, offset and increment controls. It also runs the instruction-memory request/acknowledge handshake.
- Sits between the program counter, instruction memory and the execute stage.
- Decides once per instruction whether the PC jumps, branches by an offset, or advances.
- Provides halt/resume control and a fetch-timeout watchdog.

Parameters:
FETCH_TIMEOUT, 16, cycles FETCH may wait for InstrAck before a fetch error is flagged (legal range 2..255).
IRQ_VECTOR, 16'h0004, PC load address for interrupt entry (used only with the optional feature).

Ports:
Clock  input  1  system clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
PcValue  input  16  current program counter value
PcLoadEnable  output  1  one-cycle strobe: PC loads PcLoadValue
PcLoadValue  output  16  load target for the PC
PcOffsetEnable  output  1  one-cycle strobe: PC adds PcOffset
PcOffset  output  9  branch offset; two's-complement, passed unmodified
PcAdvance  output  1  one-cycle strobe: PC increments by 1
InstrReq  output  1  instruction fetch request
InstrAddr  output  16  fetch address; equals PcValue, combinational
InstrAck  input  1  instruction memory accepts the request and returns data in the same cycle
InstrData  input  16  fetched instruction word
InstrReg  output  16  latched instruction
InstrValid  output  1  one-cycle pulse: InstrReg is new
ExecDone  input  1  execute stage finished the current instruction
JumpReq  input  1  absolute jump; sampled with ExecDone
JumpTarget  input  16  jump address
BranchReq  input  1  taken relative branch; sampled with ExecDone
BranchOffset  input  9  branch offset
HaltReq  input  1  request a halt at the next instruction boundary
Resume  input  1  leave HALT
Halted  output  1  high while in HALT
FetchError  output  1  sticky fetch-timeout flag

Behaviour:
- Reset (synchronous): state=IDLE; all strobes, InstrReq, InstrValid, Halted and FetchError are 0; InstrReg=0; PcLoadValue=0; PcOffset=0; timeout counter=0. Reset mid-handshake abandons the fetch with no strobe issued.
- States: IDLE, FETCH, EXEC, UPDATE, HALT (plus IRQ with the optional feature).
- IDLE: goes to HALT if HaltReq, otherwise to FETCH on the next cycle.
- FETCH:
  - InstrReq=1; the timeout counter increments on each cycle without InstrAck.
  - InstrAck: capture InstrData into InstrReg, clear the counter, go to EXEC.
  - Counter reaches FETCH_TIMEOUT-1 with no ack: set FetchError, drop InstrReq, go to HALT.
  - Ack on the final timeout cycle wins; no error is flagged.
- EXEC:
  - InstrValid=1 on the first EXEC cycle only.
  - Stays in EXEC until ExecDone; ExecDone may arrive on the first EXEC cycle.
  - On ExecDone, register the decision:
    - JumpReq → load JumpTarget (jump beats branch when both are asserted).
    - else BranchReq → offset by BranchOffset.
    - else → advance.
  - Then go to UPDATE.
- UPDATE:
  - Exactly one of PcLoadEnable / PcOffsetEnable / PcAdvance is high, for this cycle only.
  - PcLoadValue and PcOffset are held stable through the strobe cycle; the PC's new value is visible next cycle.
  - A branch offset of 0 still asserts PcOffsetEnable.
  - Next state: HALT if HaltReq, otherwise FETCH.
- HALT:
  - Halted=1; no strobes, no InstrReq.
  - Resume with FetchError=0 → FETCH.
  - Resume is ignored while FetchError=1; only Reset clears FetchError.
- HaltReq is sampled only in IDLE and UPDATE (instruction boundaries); at other times it has no effect.
- Minimum instruction period is 3 cycles (FETCH, EXEC, UPDATE), assuming ack and ExecDone on first opportunity.
- PC wrap-around (16'hFFFF+1, negative offsets) is the PC's responsibility; the sequencer never alters addresses.

Optional Feature:
Macro PC_SEQUENCER_IRQ_EN.
- When defined, adds these ports:
  - input Irq (level).
  - output IrqAck (1-cycle pulse).
  - output Epc[15:0] (reset 0).
- Irq is sampled in UPDATE; if high, the next state is IRQ (this takes priority over HaltReq).
- IRQ (1 cycle): Epc<=PcValue (the already-updated next PC), PcLoadEnable=1, PcLoadValue=IRQ_VECTOR, IrqAck=1, then FETCH.
- When undefined: no IRQ state and no extra ports; behaviour is exactly as above.

Test Plan:
- Reset, then InstrAck held high, ExecDone asserted on every first EXEC cycle, no jump/branch → PcAdvance pulses every 3rd cycle; InstrValid pulses once per instruction.
- ExecDone with JumpReq=1, JumpTarget=16'h1234, and also BranchReq=1 → UPDATE has PcLoadEnable=1, PcLoadValue=16'h1234, PcOffsetEnable=0.
- ExecDone with BranchReq=1, BranchOffset=9'h1FE (-2) → PcOffsetEnable=1 for exactly one cycle with PcOffset=9'h1FE; BranchOffset=0 → strobe still asserted.
- InstrAck withheld for FETCH_TIMEOUT=4 → FetchError=1 and Halted=1 after 4 FETCH cycles; Resume has no effect; Reset clears both.
- HaltReq raised during EXEC → the UPDATE strobe still occurs, then HALT; Resume → next FETCH with InstrAddr=updated PcValue.
- With PC_SEQUENCER_IRQ_EN: Irq high at UPDATE with PC advancing 16'h0010→16'h0011 → Epc=16'h0011, PcLoadValue=16'h0004, IrqAck one cycle; Reset asserted mid-EXEC → IDLE with all outputs zero next cycle.
